// File: rtl/vx_local_mem_responder.sv
// Local word-addressed memory answering Vortex mem_req/mem_rsp traffic with tagged, fixed-latency read responses.
// Optional feature macro: VX_MEM_RSP_WRITE_ACK_EN (writes also return a zero-data response carrying their tag).
module vx_local_mem_responder #(
    parameter int DATA_WIDTH     = 512,
    parameter int ADDR_WIDTH     = 26,
    parameter int TAG_WIDTH      = 56,
    parameter int DEPTH          = 1024,
    parameter int LATENCY        = 4,
    parameter int RSP_FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    mem_req_valid,
    input  logic                    mem_req_rw,
    input  logic [DATA_WIDTH/8-1:0] mem_req_byteen,
    input  logic [ADDR_WIDTH-1:0]   mem_req_addr,
    input  logic [DATA_WIDTH-1:0]   mem_req_data,
    input  logic [TAG_WIDTH-1:0]    mem_req_tag,
    output logic                    mem_req_ready,
    output logic                    mem_rsp_valid,
    output logic [DATA_WIDTH-1:0]   mem_rsp_data,
    output logic [TAG_WIDTH-1:0]    mem_rsp_tag,
    input  logic                    mem_rsp_ready,
    output logic                    tb_addr_out_of_bounds
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = $clog2(RSP_FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_WIDTH-1:0] mem_array [DEPTH];

    logic                  req_fire;
    logic                  req_oob;
    logic                  req_tracked;
    logic [IDX_W-1:0]      req_idx;
    logic [DATA_WIDTH-1:0] stage0_data;

    logic [LATENCY-1:0]    pipe_valid;
    logic [DATA_WIDTH-1:0] pipe_data [LATENCY];
    logic [TAG_WIDTH-1:0]  pipe_tag  [LATENCY];

    logic [DATA_WIDTH-1:0] fifo_data [RSP_FIFO_DEPTH];
    logic [TAG_WIDTH-1:0]  fifo_tag  [RSP_FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      head_ptr;
    logic [CNT_W-1:0]      fifo_count;
    logic                  rsp_push;
    logic                  rsp_pop;

    logic [CNT_W-1:0]      inflight;
    logic [CNT_W-1:0]      inflight_next;
    logic                  req_ready_q;
    logic                  oob_q;

    assign mem_req_ready         = req_ready_q;
    assign tb_addr_out_of_bounds = oob_q;
    assign req_fire              = mem_req_valid & req_ready_q;
    assign req_oob               = {1'b0, mem_req_addr} >= (ADDR_WIDTH + 1)'(DEPTH);
    assign req_idx               = mem_req_addr[IDX_W-1:0];

`ifdef VX_MEM_RSP_WRITE_ACK_EN
    assign req_tracked = req_fire;
`else
    assign req_tracked = req_fire & ~mem_req_rw;
`endif

    // Write acks and out-of-range reads carry zero data down the pipeline.
    assign stage0_data = (mem_req_rw || req_oob) ? '0 : mem_array[req_idx];

    always_ff @(posedge clk) begin
        if (req_fire && mem_req_rw && !req_oob) begin
            for (int i = 0; i < BYTES; i++) begin
                if (mem_req_byteen[i]) begin
                    mem_array[req_idx][i*8 +: 8] <= mem_req_data[i*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pipe_valid <= '0;
        end else begin
            pipe_valid[0] <= req_tracked;
            for (int i = 1; i < LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        pipe_data[0] <= stage0_data;
        pipe_tag[0]  <= mem_req_tag;
        for (int i = 1; i < LATENCY; i++) begin
            pipe_data[i] <= pipe_data[i-1];
            pipe_tag[i]  <= pipe_tag[i-1];
        end
    end

    // The credit counter guarantees a free slot whenever the pipeline delivers, so pushes never stall.
    assign rsp_push      = pipe_valid[LATENCY-1];
    assign mem_rsp_valid = (fifo_count != '0);
    assign rsp_pop       = mem_rsp_valid & mem_rsp_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            for (int i = 0; i < RSP_FIFO_DEPTH; i++) begin
                fifo_data[i] <= '0;
                fifo_tag[i]  <= '0;
            end
        end else begin
            if (rsp_push) begin
                fifo_data[wr_ptr] <= pipe_data[LATENCY-1];
                fifo_tag[wr_ptr]  <= pipe_tag[LATENCY-1];
                wr_ptr            <= wr_ptr + PTR_W'(1);
            end
            if (rsp_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            fifo_count <= fifo_count + CNT_W'(rsp_push) - CNT_W'(rsp_pop);
        end
    end

    // When empty, point at the slot just popped so the outputs hold the last response.
    assign head_ptr     = mem_rsp_valid ? rd_ptr : rd_ptr - PTR_W'(1);
    assign mem_rsp_data = fifo_data[head_ptr];
    assign mem_rsp_tag  = fifo_tag[head_ptr];

    always_comb begin
        inflight_next = inflight + CNT_W'(req_tracked) - CNT_W'(rsp_pop);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inflight    <= '0;
            req_ready_q <= 1'b0;
            oob_q       <= 1'b0;
        end else begin
            inflight    <= inflight_next;
            req_ready_q <= (inflight_next < CNT_W'(RSP_FIFO_DEPTH));
            if (req_fire && req_oob) begin
                oob_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vx_local_mem_responder.sv
// Self-checking bench for vx_local_mem_responder: directed scenarios plus a randomized run scored
// against a behavioural memory model and an in-order response queue.
module tb_vx_local_mem_responder;

    localparam int DW      = 512;
    localparam int AW      = 26;
    localparam int TW      = 56;
    localparam int DEPTH   = 1024;
    localparam int LATENCY = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            mem_req_valid = 1'b0;
    logic            mem_req_rw = 1'b0;
    logic [DW/8-1:0] mem_req_byteen = '0;
    logic [AW-1:0]   mem_req_addr = '0;
    logic [DW-1:0]   mem_req_data = '0;
    logic [TW-1:0]   mem_req_tag = '0;
    logic            mem_req_ready;
    logic            mem_rsp_valid;
    logic [DW-1:0]   mem_rsp_data;
    logic [TW-1:0]   mem_rsp_tag;
    logic            mem_rsp_ready = 1'b0;
    logic            tb_addr_out_of_bounds;

    int tests_run = 0;
    int tests_failed = 0;

    logic [DW-1:0]    model_mem [DEPTH];
    logic [TW+DW-1:0] exp_q [$];
    logic [DW-1:0]    pat_a5;
    bit               drv_done;

    vx_local_mem_responder dut (
        .clk                   (clk),
        .reset                 (reset),
        .mem_req_valid         (mem_req_valid),
        .mem_req_rw            (mem_req_rw),
        .mem_req_byteen        (mem_req_byteen),
        .mem_req_addr          (mem_req_addr),
        .mem_req_data          (mem_req_data),
        .mem_req_tag           (mem_req_tag),
        .mem_req_ready         (mem_req_ready),
        .mem_rsp_valid         (mem_rsp_valid),
        .mem_rsp_data          (mem_rsp_data),
        .mem_rsp_tag           (mem_rsp_tag),
        .mem_rsp_ready         (mem_rsp_ready),
        .tb_addr_out_of_bounds (tb_addr_out_of_bounds)
    );

    always #5 clk = ~clk;

    // Drive one request until accepted; the model is updated at the moment acceptance is certain.
    task automatic send(input bit rw, input logic [AW-1:0] addr, input logic [DW/8-1:0] be,
                        input logic [DW-1:0] data, input logic [TW-1:0] tag);
        int waited = 0;
        @(negedge clk);
        mem_req_valid  = 1'b1;
        mem_req_rw     = rw;
        mem_req_addr   = addr;
        mem_req_byteen = be;
        mem_req_data   = data;
        mem_req_tag    = tag;
        while (!mem_req_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!mem_req_ready) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL req_accept_timeout: ready=%0b required 1", mem_req_ready);
        end else begin
            if (rw) begin
                if (addr < AW'(DEPTH)) begin
                    for (int i = 0; i < DW/8; i++) begin
                        if (be[i]) model_mem[addr[9:0]][i*8 +: 8] = data[i*8 +: 8];
                    end
                end
`ifdef VX_MEM_RSP_WRITE_ACK_EN
                exp_q.push_back({tag, {DW{1'b0}}});
`endif
            end else begin
                exp_q.push_back({tag, (addr < AW'(DEPTH)) ? model_mem[addr[9:0]] : {DW{1'b0}}});
            end
            @(posedge clk);
            #1;
        end
        mem_req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output logic [TW-1:0] tag, output logic [DW-1:0] data);
        int n = 0;
        @(negedge clk);
        mem_rsp_ready = 1'b1;
        while (!mem_rsp_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!mem_rsp_valid) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL rsp_timeout: rsp_valid=%0b required 1", mem_rsp_valid);
            tag  = '0;
            data = '0;
        end else begin
            tag  = mem_rsp_tag;
            data = mem_rsp_data;
        end
        @(posedge clk);
        #1;
        mem_rsp_ready = 1'b0;
    endtask

`ifdef VX_MEM_RSP_WRITE_ACK_EN
    task automatic drain_ack(input logic [TW-1:0] exp_tag);
        logic [TW-1:0] t;
        logic [DW-1:0] d;
        wait_rsp(t, d);
        tests_run++;
        if (t !== exp_tag || d !== '0) begin
            tests_failed++;
            $display("[TB] FAIL write_ack: tag=%h data=%h required tag=%h data=0", t, d, exp_tag);
        end
    endtask
`endif

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (mem_req_ready !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_ready: got %0b required 0", mem_req_ready);
        end
        tests_run++;
        if (mem_rsp_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_rsp_valid: got %0b required 0", mem_rsp_valid);
        end
        tests_run++;
        if (mem_rsp_tag !== '0 || mem_rsp_data !== '0) begin
            tests_failed++;
            $display("[TB] FAIL reset_rsp_payload: tag=%h data=%h required 0", mem_rsp_tag, mem_rsp_data);
        end
        tests_run++;
        if (tb_addr_out_of_bounds !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_oob: got %0b required 0", tb_addr_out_of_bounds);
        end
        reset = 1'b1;
        @(negedge clk);
        tests_run++;
        if (mem_req_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL ready_after_release: got %0b required 1", mem_req_ready);
        end
    endtask

    task automatic test_write_read();
        send(1'b1, 26'h10, '1, pat_a5, 56'd1);
`ifdef VX_MEM_RSP_WRITE_ACK_EN
        drain_ack(56'd1);
`endif
        mem_rsp_ready = 1'b0;
        send(1'b0, 26'h10, '0, '0, 56'd7);
        for (int k = 0; k <= LATENCY; k++) begin
            @(negedge clk);
            tests_run++;
            if (mem_rsp_valid !== (k == LATENCY)) begin
                tests_failed++;
                $display("[TB] FAIL read_latency: cycle %0d rsp_valid=%0b required %0b",
                         k, mem_rsp_valid, (k == LATENCY));
            end
        end
        tests_run++;
        if (mem_rsp_tag !== 56'd7 || mem_rsp_data !== pat_a5) begin
            tests_failed++;
            $display("[TB] FAIL read_after_write: tag=%h data=%h required tag=7 data=%h",
                     mem_rsp_tag, mem_rsp_data, pat_a5);
        end
        mem_rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        mem_rsp_ready = 1'b0;
        @(negedge clk);
        tests_run++;
        if (mem_rsp_valid !== 1'b0 || mem_rsp_tag !== 56'd7) begin
            tests_failed++;
            $display("[TB] FAIL empty_hold: rsp_valid=%0b tag=%h required valid=0 tag=7",
                     mem_rsp_valid, mem_rsp_tag);
        end
    endtask

    task automatic test_byte_enable();
        logic [TW-1:0] t;
        logic [DW-1:0] d;
        logic [DW-1:0] expected;
        send(1'b1, 26'h3, '1, '0, 56'd2);
`ifdef VX_MEM_RSP_WRITE_ACK_EN
        drain_ack(56'd2);
`endif
        send(1'b1, 26'h3, 64'h1, '1, 56'd3);
`ifdef VX_MEM_RSP_WRITE_ACK_EN
        drain_ack(56'd3);
`endif
        send(1'b0, 26'h3, '0, '0, 56'd4);
        wait_rsp(t, d);
        expected = '0;
        expected[7:0] = 8'hFF;
        tests_run++;
        if (t !== 56'd4 || d !== expected) begin
            tests_failed++;
            $display("[TB] FAIL byte_enable: tag=%h data=%h required tag=4 data=%h", t, d, expected);
        end
    endtask

    task automatic test_backpressure();
        int accepted = 0;
        int returned = 0;
        int cyc = 0;
        mem_rsp_ready = 1'b0;
        while (accepted < 6 && cyc < 20) begin
            @(negedge clk);
            cyc++;
            mem_req_valid = 1'b1;
            mem_req_rw    = 1'b0;
            mem_req_addr  = 26'h10;
            mem_req_tag   = 56'h30 + TW'(accepted);
            if (mem_req_ready) begin
                @(posedge clk);
                accepted++;
            end
        end
        @(negedge clk);
        tests_run++;
        if (accepted != 4) begin
            tests_failed++;
            $display("[TB] FAIL credit_limit: accepted %0d required 4", accepted);
        end
        tests_run++;
        if (mem_req_ready !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL ready_when_full: got %0b required 0", mem_req_ready);
        end
        mem_rsp_ready = 1'b1;
        cyc = 0;
        while (returned < 6 && cyc < 60) begin
            if (mem_rsp_valid) begin
                tests_run++;
                if (mem_rsp_tag !== 56'h30 + TW'(returned) || mem_rsp_data !== pat_a5) begin
                    tests_failed++;
                    $display("[TB] FAIL rsp_order: tag=%h required %h", mem_rsp_tag, 56'h30 + TW'(returned));
                end
                returned++;
            end
            if (mem_req_valid && mem_req_ready) accepted++;
            @(posedge clk);
            #1;
            if (accepted >= 6) mem_req_valid = 1'b0;
            else mem_req_tag = 56'h30 + TW'(accepted);
            @(negedge clk);
            cyc++;
        end
        mem_req_valid = 1'b0;
        mem_rsp_ready = 1'b0;
        tests_run++;
        if (returned != 6 || accepted != 6) begin
            tests_failed++;
            $display("[TB] FAIL backpressure_drain: returned %0d accepted %0d required 6 and 6", returned, accepted);
        end
    endtask

    task automatic test_out_of_bounds();
        logic [TW-1:0] t;
        logic [DW-1:0] d;
        send(1'b0, AW'(DEPTH), '0, '0, 56'd9);
        wait_rsp(t, d);
        tests_run++;
        if (t !== 56'd9 || d !== '0) begin
            tests_failed++;
            $display("[TB] FAIL oob_read: tag=%h data=%h required tag=9 data=0", t, d);
        end
        tests_run++;
        if (tb_addr_out_of_bounds !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL oob_flag: got %0b required 1", tb_addr_out_of_bounds);
        end
        send(1'b1, AW'(DEPTH + 'h10), '1, {64{8'h5A}}, 56'd10);
`ifdef VX_MEM_RSP_WRITE_ACK_EN
        drain_ack(56'd10);
`endif
        send(1'b0, 26'h10, '0, '0, 56'd11);
        wait_rsp(t, d);
        tests_run++;
        if (t !== 56'd11 || d !== pat_a5) begin
            tests_failed++;
            $display("[TB] FAIL oob_write_dropped: tag=%h data=%h required tag=b data=%h", t, d, pat_a5);
        end
        tests_run++;
        if (tb_addr_out_of_bounds !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL oob_sticky: got %0b required 1", tb_addr_out_of_bounds);
        end
    endtask

    task automatic test_reset_midflight();
        logic [TW-1:0] t;
        logic [DW-1:0] d;
        bit            stale = 1'b0;
        mem_rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(1'b0, 26'h10, '0, '0, 56'h40 + TW'(i));
        @(posedge clk);
        @(posedge clk);
        #1;
        tests_run++;
        if (mem_rsp_valid !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL midflight_pre: rsp_valid=%0b required 1", mem_rsp_valid);
        end
        reset = 1'b0;
        #1;
        tests_run++;
        if (mem_rsp_valid !== 1'b0 || mem_req_ready !== 1'b0 || tb_addr_out_of_bounds !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL async_reset: rsp_valid=%0b ready=%0b oob=%0b required 0 0 0",
                     mem_rsp_valid, mem_req_ready, tb_addr_out_of_bounds);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        mem_rsp_ready = 1'b1;
        repeat (3 * LATENCY + 4) begin
            @(negedge clk);
            if (mem_rsp_valid) stale = 1'b1;
        end
        mem_rsp_ready = 1'b0;
        tests_run++;
        if (stale) begin
            tests_failed++;
            $display("[TB] FAIL stale_response: saw rsp_valid=1 required none");
        end
        send(1'b0, 26'h10, '0, '0, 56'h50);
        wait_rsp(t, d);
        tests_run++;
        if (t !== 56'h50 || d !== pat_a5) begin
            tests_failed++;
            $display("[TB] FAIL array_kept: tag=%h data=%h required tag=50 data=%h", t, d, pat_a5);
        end
    endtask

    task automatic test_write_ack();
        logic [TW-1:0] t;
        logic [DW-1:0] d;
        logic [DW-1:0] wdata;
        wdata = {16{32'h1234_5678}};
        send(1'b1, 26'h20, '1, wdata, 56'h2A);
`ifdef VX_MEM_RSP_WRITE_ACK_EN
        wait_rsp(t, d);
        tests_run++;
        if (t !== 56'h2A || d !== '0) begin
            tests_failed++;
            $display("[TB] FAIL write_ack_rsp: tag=%h data=%h required tag=2a data=0", t, d);
        end
`else
        begin
            bit seen = 1'b0;
            mem_rsp_ready = 1'b1;
            repeat (2 * LATENCY + 4) begin
                @(negedge clk);
                if (mem_rsp_valid) seen = 1'b1;
            end
            mem_rsp_ready = 1'b0;
            tests_run++;
            if (seen) begin
                tests_failed++;
                $display("[TB] FAIL write_no_rsp: saw rsp_valid=1 required none");
            end
        end
`endif
        send(1'b0, 26'h20, '0, '0, 56'h2B);
        wait_rsp(t, d);
        tests_run++;
        if (t !== 56'h2B || d !== wdata) begin
            tests_failed++;
            $display("[TB] FAIL write_data: tag=%h data=%h required tag=2b data=%h", t, d, wdata);
        end
    endtask

    task automatic test_random();
        exp_q.delete();
        drv_done = 1'b0;
        fork
            begin
                logic [DW-1:0]   data;
                logic [DW/8-1:0] be;
                logic [AW-1:0]   addr;
                for (int a = 0; a < 32; a++) begin
                    for (int w = 0; w < DW/32; w++) data[w*32 +: 32] = $urandom;
                    send(1'b1, AW'(a), '1, data, TW'(a));
                end
                for (int n = 0; n < 200; n++) begin
                    for (int w = 0; w < DW/32; w++) data[w*32 +: 32] = $urandom;
                    be   = {$urandom, $urandom};
                    addr = ($urandom_range(0, 15) == 0) ? AW'(DEPTH + $urandom_range(0, 31))
                                                        : AW'($urandom_range(0, 31));
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                    send(1'($urandom_range(0, 1)), addr, be, data, TW'({$urandom, $urandom}));
                end
                drv_done = 1'b1;
            end
            begin
                int cyc = 0;
                logic [TW+DW-1:0] exp;
                while (!(drv_done && exp_q.size() == 0) && cyc < 20000) begin
                    @(negedge clk);
                    cyc++;
                    mem_rsp_ready = ($urandom_range(0, 3) != 0);
                    if (mem_rsp_valid && mem_rsp_ready) begin
                        tests_run++;
                        if (exp_q.size() == 0) begin
                            tests_failed++;
                            $display("[TB] FAIL random_unexpected: tag=%h required no response", mem_rsp_tag);
                        end else begin
                            exp = exp_q.pop_front();
                            if ({mem_rsp_tag, mem_rsp_data} !== exp) begin
                                tests_failed++;
                                $display("[TB] FAIL random_rsp: tag=%h data=%h required tag=%h data=%h",
                                         mem_rsp_tag, mem_rsp_data, exp[TW+DW-1:DW], exp[DW-1:0]);
                            end
                        end
                    end
                end
                if (cyc >= 20000) begin
                    tests_run++;
                    tests_failed++;
                    $display("[TB] FAIL random_timeout: %0d responses outstanding required 0", exp_q.size());
                end
                mem_rsp_ready = 1'b0;
            end
        join
    endtask

    initial begin
        pat_a5 = {64{8'hA5}};
        test_reset();
        test_write_read();
        test_byte_enable();
        test_backpressure();
        test_out_of_bounds();
        test_reset_midflight();
        test_write_ack();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
